// File: rtl/grid_overlay_pkg.sv
// Shared constants, types and helpers for the grid overlay printer.
package grid_overlay_pkg;

   // Default geometry for a 640x480 screen with a 3x3 board.
   localparam int H_ACTIVE_DEF     = 640;
   localparam int V_ACTIVE_DEF     = 480;
   localparam int COLS_DEF         = 3;
   localparam int ROWS_DEF         = 3;
   localparam int LINE_W_DEF       = 5;
   localparam int CUR_W_DEF        = 3;
   localparam int BLINK_FRAMES_DEF = 30;

   // Default colours.
   localparam logic [23:0] LINE_RGB_DEF = 24'h000000;
   localparam logic [23:0] CUR_RGB_DEF  = 24'hFF0000;

   // Wide enough for any board index the printer is likely to be built with.
   localparam int CELL_IDX_W = 4;

   // A board cell coordinate.
   typedef struct packed {
      logic [CELL_IDX_W-1:0] col;
      logic [CELL_IDX_W-1:0] row;
   } cell_t;

   // True when v lies in the closed interval [lo, hi].
   function automatic logic in_band(input int v, input int lo, input int hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/blink_timer.sv
// Frame counter and blink phase for the cursor border.
// phase = 1 means the cursor is visible. restart forces a fresh, visible
// half-period and wins over a coincident frame_start.
module blink_timer
   import grid_overlay_pkg::*;
#(
   parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic frame_start,
   input  logic restart,
   output logic phase
);

   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic             phase_q;

   // Count frames; toggle the phase after BLINK_FRAMES of them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else if (restart) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else if (frame_start) begin
         if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/grid_overlay_printer.sv
// Grid and blinking-cursor overlay for the VGA pixel path.
// One clock of latency from (x, y) to print/rgb. Grid lines take priority
// over the cursor border; pixels outside the active area never print.
module grid_overlay_printer
   import grid_overlay_pkg::*;
#(
   parameter int          H_ACTIVE     = H_ACTIVE_DEF,
   parameter int          V_ACTIVE     = V_ACTIVE_DEF,
   parameter int          COLS         = COLS_DEF,
   parameter int          ROWS         = ROWS_DEF,
   parameter int          LINE_W       = LINE_W_DEF,
   parameter int          CUR_W        = CUR_W_DEF,
   parameter int          BLINK_FRAMES = BLINK_FRAMES_DEF,
   parameter logic [23:0] LINE_RGB     = LINE_RGB_DEF,
   parameter logic [23:0] CUR_RGB      = CUR_RGB_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [9:0]                x,
   input  logic [9:0]                y,
   input  logic                      frame_start,
   input  logic                      move_up,
   input  logic                      move_down,
   input  logic                      move_left,
   input  logic                      move_right,
   input  logic                      sel,
   output logic                      print,
   output logic [23:0]               rgb,
   output logic [$clog2(COLS)-1:0]   cur_col,
   output logic [$clog2(ROWS)-1:0]   cur_row,
   output logic                      sel_valid,
   output logic [$clog2(COLS)-1:0]   sel_col,
   output logic [$clog2(ROWS)-1:0]   sel_row
);

   localparam int CELL_W = H_ACTIVE / COLS;
   localparam int CELL_H = V_ACTIVE / ROWS;
   localparam int HALF   = LINE_W / 2;
   localparam int CW     = $clog2(COLS);
   localparam int RW     = $clog2(ROWS);

   logic [CW-1:0] cur_col_q, cur_col_d;
   logic [RW-1:0] cur_row_q, cur_row_d;
   logic [CW-1:0] sel_col_q;
   logic [RW-1:0] sel_row_q;
   logic          sel_valid_q;
   logic          print_q, print_d;
   logic [23:0]   rgb_q, rgb_d;
   logic          move_applied;
   logic          phase;

   blink_timer #(
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_blink (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .restart     (move_applied),
      .phase       (phase)
   );

   // Cursor next state: one move per cycle, up > down > left > right, with wrap.
   always_comb begin : move_logic
      cur_col_d    = cur_col_q;
      cur_row_d    = cur_row_q;
      move_applied = move_up | move_down | move_left | move_right;
      if (move_up) begin
         cur_row_d = (cur_row_q == '0) ? RW'(ROWS - 1) : cur_row_q - RW'(1);
      end else if (move_down) begin
         cur_row_d = (cur_row_q == RW'(ROWS - 1)) ? '0 : cur_row_q + RW'(1);
      end else if (move_left) begin
         cur_col_d = (cur_col_q == '0) ? CW'(COLS - 1) : cur_col_q - CW'(1);
      end else if (move_right) begin
         cur_col_d = (cur_col_q == CW'(COLS - 1)) ? '0 : cur_col_q + CW'(1);
      end
   end

   // Pixel classification against the grid lines and the cursor cell border.
   always_comb begin : hit_logic
      int   xi, yi, xlo, xhi, ylo, yhi;
      logic grid_hit, in_span, near_edge, cur_hit, in_active;
      xi        = int'(x);
      yi        = int'(y);
      grid_hit  = 1'b0;
      for (int k = 1; k < COLS; k++) begin
         if (in_band(xi, k * CELL_W - HALF, k * CELL_W + HALF)) grid_hit = 1'b1;
      end
      for (int k = 1; k < ROWS; k++) begin
         if (in_band(yi, k * CELL_H - HALF, k * CELL_H + HALF)) grid_hit = 1'b1;
      end
      // The last column/row absorbs the remainder of the integer division.
      xlo       = int'(cur_col_q) * CELL_W;
      xhi       = (int'(cur_col_q) == COLS - 1) ? H_ACTIVE - 1 : xlo + CELL_W - 1;
      ylo       = int'(cur_row_q) * CELL_H;
      yhi       = (int'(cur_row_q) == ROWS - 1) ? V_ACTIVE - 1 : ylo + CELL_H - 1;
      in_span   = in_band(xi, xlo, xhi) && in_band(yi, ylo, yhi);
      near_edge = (xi < xlo + CUR_W) || (xi > xhi - CUR_W) ||
                  (yi < ylo + CUR_W) || (yi > yhi - CUR_W);
      cur_hit   = phase && in_span && near_edge;
      in_active = (xi < H_ACTIVE) && (yi < V_ACTIVE);
      print_d   = 1'b0;
      rgb_d     = '0;
      if (in_active) begin
         if (grid_hit) begin
            print_d = 1'b1;
            rgb_d   = LINE_RGB;
         end else if (cur_hit) begin
            print_d = 1'b1;
            rgb_d   = CUR_RGB;
         end
      end
   end

   // Output pixel register, cursor position and select capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         print_q     <= 1'b0;
         rgb_q       <= '0;
         cur_col_q   <= '0;
         cur_row_q   <= '0;
         sel_valid_q <= 1'b0;
         sel_col_q   <= '0;
         sel_row_q   <= '0;
      end else begin
         print_q     <= print_d;
         rgb_q       <= rgb_d;
         cur_col_q   <= cur_col_d;
         cur_row_q   <= cur_row_d;
         sel_valid_q <= sel;
         // Capture the pre-move cursor so a select pairs with what was shown.
         if (sel) begin
            sel_col_q <= cur_col_q;
            sel_row_q <= cur_row_q;
         end
      end
   end

   assign print     = print_q;
   assign rgb       = rgb_q;
   assign cur_col   = cur_col_q;
   assign cur_row   = cur_row_q;
   assign sel_valid = sel_valid_q;
   assign sel_col   = sel_col_q;
   assign sel_row   = sel_row_q;

endmodule
